// File: rtl/dm_access_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dm_access_arbiter                                                          |
// | Shares the data-memory port between the M-stage CPU access and an external |
// | requester; sequences multi-cycle accesses and stalls the pipeline.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module dm_access_arbiter #(
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic [31:0] cpu_addr,
  input  logic [3:0]  cpu_byte_en,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        ext_req,
  input  logic [31:0] ext_addr,
  input  logic [3:0]  ext_byte_en,
  input  logic [31:0] ext_wdata,
  output logic [31:0] ext_rdata,
  output logic        ext_ack,
  output logic        mem_en,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_byte_en,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int STV_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);
  localparam logic [STV_W-1:0] STV_LIMIT = STV_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_EXT = 1'b1
  } owner_e;

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [STV_W-1:0]  starve_q, starve_d;
  logic [31:0]       addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              ext_wins;

  // EXT takes the grant when alone, or when it has lost often enough.
  assign ext_wins = ext_req && (!cpu_req || (starve_q >= STV_LIMIT));

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    starve_d = starve_q;
    addr_d   = addr_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (!ext_req || ext_wins) begin
          starve_d = '0;
        end else if (starve_q < STV_LIMIT) begin
          starve_d = starve_q + STV_W'(1);
        end
        if (cpu_req || ext_req) begin
          owner_d = ext_wins ? OWN_EXT : OWN_CPU;
          addr_d  = ext_wins ? ext_addr    : cpu_addr;
          be_d    = ext_wins ? ext_byte_en : cpu_byte_en;
          wdata_d = ext_wins ? ext_wdata   : cpu_wdata;
          cnt_d   = CNT_INIT;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (cnt_q == '0) begin
          rdata_d = mem_rdata;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      owner_q  <= OWN_CPU;
      cnt_q    <= '0;
      starve_q <= '0;
      addr_q   <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
      addr_q   <= addr_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
    end
  end

  logic cpu_done;
  logic ext_done;

  assign cpu_done    = (state_q == S_DONE) && (owner_q == OWN_CPU);
  assign ext_done    = (state_q == S_DONE) && (owner_q == OWN_EXT);
  assign cpu_stall   = cpu_req && !cpu_done;
  assign cpu_rdata   = cpu_done ? rdata_q : 32'h0;
  assign ext_ack     = ext_done;
  assign ext_rdata   = ext_done ? rdata_q : 32'h0;
  assign mem_en      = (state_q == S_BUSY);
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign mem_byte_en = mem_en ? be_q : 4'h0;

endmodule
`default_nettype wire

// File: tb/tb_dm_access_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_dm_access_arbiter                                                       |
// | Directed checks of dm_access_arbiter for MEM_LAT=2 and MEM_LAT=1.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_dm_access_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 1'b0, ext_req = 1'b0;
  logic        cpu_req1 = 1'b0, ext_req1 = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0, ext_addr = '0, ext_wdata = '0;
  logic [3:0]  cpu_byte_en = '0, ext_byte_en = '0;
  logic [31:0] mem_rdata = '0;

  logic [31:0] cpu_rdata, ext_rdata, mem_addr, mem_wdata;
  logic        cpu_stall, ext_ack, mem_en;
  logic [3:0]  mem_byte_en;
  logic [31:0] cpu_rdata1, ext_rdata1, mem_addr1, mem_wdata1;
  logic        cpu_stall1, ext_ack1, mem_en1;
  logic [3:0]  mem_byte_en1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dm_access_arbiter #(.MEM_LAT(2), .STARVE_MAX(4)) u0 (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_byte_en(cpu_byte_en), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .ext_req(ext_req), .ext_addr(ext_addr), .ext_byte_en(ext_byte_en), .ext_wdata(ext_wdata),
    .ext_rdata(ext_rdata), .ext_ack(ext_ack),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_byte_en(mem_byte_en), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  dm_access_arbiter #(.MEM_LAT(1), .STARVE_MAX(4)) u1 (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req1), .cpu_addr(cpu_addr), .cpu_byte_en(cpu_byte_en), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata1), .cpu_stall(cpu_stall1),
    .ext_req(ext_req1), .ext_addr(ext_addr), .ext_byte_en(ext_byte_en), .ext_wdata(ext_wdata),
    .ext_rdata(ext_rdata1), .ext_ack(ext_ack1),
    .mem_en(mem_en1), .mem_addr(mem_addr1), .mem_byte_en(mem_byte_en1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cpu_done, ext_done, last_cpu, ack_cyc, stall_hi;
    logic [31:0] ack_data;

    // Reset state
    #1;
    chk("rst_mem_en", {31'b0, mem_en}, 32'h0);
    chk("rst_mem_be", {28'b0, mem_byte_en}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_ext_ack", {31'b0, ext_ack}, 32'h0);
    chk("rst_cpu_rdata", cpu_rdata, 32'h0);
    cpu_req = 1'b1;
    #1;
    chk("rst_stall_follows_req", {31'b0, cpu_stall}, 32'h1);
    cpu_req = 1'b0;
    #1;
    chk("rst_stall_idle", {31'b0, cpu_stall}, 32'h0);
    next_cycle();
    next_cycle();
    reset = 1'b0;

    // 1: CPU read, MEM_LAT=2
    next_cycle();
    cpu_req = 1'b1; cpu_addr = 32'h10; cpu_byte_en = 4'h0; mem_rdata = 32'hDEADBEEF;
    sample();
    chk("t1_c1_stall", {31'b0, cpu_stall}, 32'h1);
    chk("t1_c1_mem_en", {31'b0, mem_en}, 32'h0);
    next_cycle(); sample();
    chk("t1_c2_mem_en", {31'b0, mem_en}, 32'h1);
    chk("t1_c2_mem_addr", mem_addr, 32'h10);
    chk("t1_c2_stall", {31'b0, cpu_stall}, 32'h1);
    chk("t1_c2_rdata_zero", cpu_rdata, 32'h0);
    next_cycle(); sample();
    chk("t1_c3_mem_en", {31'b0, mem_en}, 32'h1);
    chk("t1_c3_stall", {31'b0, cpu_stall}, 32'h1);
    next_cycle(); sample();
    chk("t1_c4_mem_en", {31'b0, mem_en}, 32'h0);
    chk("t1_c4_stall", {31'b0, cpu_stall}, 32'h0);
    chk("t1_c4_rdata", cpu_rdata, 32'hDEADBEEF);
    next_cycle();
    cpu_req = 1'b0;
    sample();
    chk("t1_c5_rdata_zero", cpu_rdata, 32'h0);

    // 2: CPU store
    next_cycle();
    cpu_req = 1'b1; cpu_addr = 32'h20; cpu_byte_en = 4'b0011; cpu_wdata = 32'h0000ABCD;
    mem_rdata = 32'h55555555;
    sample();
    chk("t2_c1_mem_be", {28'b0, mem_byte_en}, 32'h0);
    next_cycle(); sample();
    chk("t2_c2_mem_be", {28'b0, mem_byte_en}, 32'h3);
    chk("t2_c2_mem_addr", mem_addr, 32'h20);
    chk("t2_c2_mem_wdata", mem_wdata, 32'h0000ABCD);
    next_cycle(); sample();
    chk("t2_c3_mem_be", {28'b0, mem_byte_en}, 32'h3);
    chk("t2_c3_stall", {31'b0, cpu_stall}, 32'h1);
    next_cycle(); sample();
    chk("t2_c4_stall", {31'b0, cpu_stall}, 32'h0);
    chk("t2_c4_ext_ack", {31'b0, ext_ack}, 32'h0);
    chk("t2_c4_mem_be", {28'b0, mem_byte_en}, 32'h0);
    next_cycle();
    cpu_req = 1'b0; cpu_byte_en = 4'h0;

    // 3: contention, CPU wins 4 times then EXT
    next_cycle();
    cpu_req = 1'b1; cpu_addr = 32'h10; ext_req = 1'b1; ext_addr = 32'h80; ext_byte_en = 4'h0;
    mem_rdata = 32'h12345678;
    cpu_done = 0; ext_done = 0; last_cpu = 0; ack_cyc = 0; stall_hi = 0; ack_data = '0;
    for (int c = 1; c <= 20; c++) begin
      if (c > 1) next_cycle();
      sample();
      if (!cpu_stall) begin cpu_done++; last_cpu = c; end
      if (ext_ack) begin ext_done++; ack_cyc = c; ack_data = ext_rdata; end
      if (c >= 17 && cpu_stall) stall_hi++;
    end
    chk("t3_cpu_completions", cpu_done, 32'd4);
    chk("t3_last_cpu_cycle", last_cpu, 32'd16);
    chk("t3_ext_acks", ext_done, 32'd1);
    chk("t3_ext_ack_cycle", ack_cyc, 32'd20);
    chk("t3_ext_rdata", ack_data, 32'h12345678);
    chk("t3_stall_through_ext", stall_hi, 32'd4);
    next_cycle();
    cpu_req = 1'b0; ext_req = 1'b0;

    // 4: EXT-only read
    next_cycle();
    ext_req = 1'b1; ext_addr = 32'h40; mem_rdata = 32'hCAFEF00D;
    sample();
    chk("t4_c1_ack", {31'b0, ext_ack}, 32'h0);
    chk("t4_c1_stall", {31'b0, cpu_stall}, 32'h0);
    next_cycle(); sample();
    chk("t4_c2_mem_addr", mem_addr, 32'h40);
    next_cycle(); sample();
    chk("t4_c3_ack", {31'b0, ext_ack}, 32'h0);
    next_cycle(); sample();
    chk("t4_c4_ack", {31'b0, ext_ack}, 32'h1);
    chk("t4_c4_rdata", ext_rdata, 32'hCAFEF00D);
    chk("t4_c4_stall", {31'b0, cpu_stall}, 32'h0);
    next_cycle();
    ext_req = 1'b0;
    sample();
    chk("t4_c5_ack", {31'b0, ext_ack}, 32'h0);
    chk("t4_c5_rdata_zero", ext_rdata, 32'h0);

    // 5: reset during BUSY, then the held request is regranted
    next_cycle();
    cpu_req = 1'b1; cpu_addr = 32'h30; mem_rdata = 32'hA5A5A5A5;
    next_cycle(); sample();
    chk("t5_busy_mem_en", {31'b0, mem_en}, 32'h1);
    #2;
    reset = 1'b1;
    #1;
    chk("t5_async_mem_en", {31'b0, mem_en}, 32'h0);
    chk("t5_rst_stall", {31'b0, cpu_stall}, 32'h1);
    next_cycle();
    next_cycle();
    reset = 1'b0;
    cpu_done = 0; ext_done = 0; last_cpu = 0; ack_data = '0;
    for (int c = 1; c <= 4; c++) begin
      if (c > 1) next_cycle();
      sample();
      if (!cpu_stall) begin cpu_done++; last_cpu = c; ack_data = cpu_rdata; end
      if (ext_ack) ext_done++;
    end
    chk("t5_completions", cpu_done, 32'd1);
    chk("t5_completion_cycle", last_cpu, 32'd4);
    chk("t5_rdata", ack_data, 32'hA5A5A5A5);
    chk("t5_no_ext_ack", ext_done, 32'd0);
    next_cycle();
    cpu_req = 1'b0;

    // 6: MEM_LAT=1 instance
    next_cycle();
    cpu_req1 = 1'b1; cpu_addr = 32'h50; mem_rdata = 32'h0BADF00D;
    sample();
    chk("t6_c1_mem_en", {31'b0, mem_en1}, 32'h0);
    next_cycle(); sample();
    chk("t6_c2_mem_en", {31'b0, mem_en1}, 32'h1);
    chk("t6_c2_stall", {31'b0, cpu_stall1}, 32'h1);
    next_cycle(); sample();
    chk("t6_c3_mem_en", {31'b0, mem_en1}, 32'h0);
    chk("t6_c3_stall", {31'b0, cpu_stall1}, 32'h0);
    chk("t6_c3_rdata", cpu_rdata1, 32'h0BADF00D);
    next_cycle();
    cpu_req1 = 1'b0;

    next_cycle();
    cpu_req1 = 1'b1; ext_req1 = 1'b1;
    cpu_done = 0; ext_done = 0; ack_cyc = 0;
    for (int c = 1; c <= 15; c++) begin
      if (c > 1) next_cycle();
      sample();
      if (!cpu_stall1) cpu_done++;
      if (ext_ack1) begin ext_done++; ack_cyc = c; end
      if (c == 12) chk("t6_starve_saturated", {29'b0, u1.starve_q}, 32'd4);
    end
    chk("t6_cpu_completions", cpu_done, 32'd4);
    chk("t6_ext_acks", ext_done, 32'd1);
    chk("t6_ext_ack_cycle", ack_cyc, 32'd15);
    next_cycle();
    cpu_req1 = 1'b0; ext_req1 = 1'b0;
    next_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
